// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared widths, state encoding and byte counts for the d_cache preload path
//
// Purpose : common constants used by dmem_preloader and preload_byte_packer.
// Ports   : none (package).
// Macro   : DMEM_PRELOAD_CSUM_EN adds the TAIL (checksum byte) state to preload_state_e.
package rv32i_pkg;

    localparam int DPW = 32;              // data word width
    localparam int ADW = 7;               // d_cache byte address width (120-byte array)

    localparam int PreloadHdrBytes = 4;   // bytes per header field (BASE, COUNT)
    localparam int WordBytes       = DPW / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_HDR_CNT,
        ST_DATA,
        ST_WRITE,
`ifdef DMEM_PRELOAD_CSUM_EN
        ST_TAIL,
`endif
        ST_DONE
    } preload_state_e;

endpackage

// File: rtl/preload_byte_packer.sv
// rtl/preload_byte_packer.sv - little-endian byte-to-word assembler shared by header and data fields
//
// Purpose : shifts accepted bytes into a word, first byte ending up in bits [7:0].
//           o_word is the word including the byte being accepted this cycle, so
//           o_word is complete in the same cycle o_word_valid pulses.
// Ports   : clk, arst_ni      clock, asynchronous active-low reset
//           i_clear           restart byte counting at byte 0
//           i_accept, i_byte  byte handshake completed this cycle, and its value
//           o_word            assembled word (valid while o_word_valid)
//           o_word_valid      last byte of a word is being accepted
module preload_byte_packer
    import rv32i_pkg::*;
#(
    parameter int Bytes = WordBytes
) (
    input  logic               clk,
    input  logic               arst_ni,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [7:0]         i_byte,
    output logic [8*Bytes-1:0] o_word,
    output logic               o_word_valid
);

    localparam int CntW = $clog2(Bytes);
    localparam logic [CntW-1:0] LastIdx = CntW'(Bytes - 1);

    logic [CntW-1:0]          r_cnt;
    // Only the first Bytes-1 bytes need storing; the last one comes straight from i_byte.
    logic [8*(Bytes-1)-1:0]   r_shift;

    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_accept && (r_cnt == LastIdx);

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
        end else if (i_accept) begin
            r_shift <= {i_byte, r_shift[8*(Bytes-1)-1:8]};
            r_cnt   <= o_word_valid ? '0 : r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/dmem_preloader.sv
// rtl/dmem_preloader.sv - byte-stream loader that writes words into the d_cache preload port
//
// Purpose : parses BASE(4) | COUNT(4) | COUNT*4 data bytes (all little-endian) and issues
//           one data_en_o write per word at BASE + 4*i (wrapping in ADW bits).
// Ports   : clk, arst_ni                  clock, asynchronous active-low reset
//           start_i                       pulse that opens a session (ignored while busy)
//           s_data_i, s_valid_i, s_ready_o byte stream handshake
//           data_en_o, input_addr_o, input_data_o   d_cache preload write
//           busy_o                        session in progress (holds core in reset)
//           done_o                        one-cycle end-of-session pulse
//           err_o                         sticky error of the last session
// Macro   : DMEM_PRELOAD_CSUM_EN - after the data a TAIL byte is accepted and compared against
//           the XOR of all data bytes; a mismatch sets err_o.
module dmem_preloader #(
    parameter int DPW      = rv32i_pkg::DPW,
    parameter int ADW      = rv32i_pkg::ADW,
    parameter int MaxWords = 30
) (
    input  logic           clk,
    input  logic           arst_ni,
    input  logic           start_i,
    input  logic [7:0]     s_data_i,
    input  logic           s_valid_i,
    output logic           s_ready_o,
    output logic           data_en_o,
    output logic [DPW-1:0] input_addr_o,
    output logic [DPW-1:0] input_data_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    import rv32i_pkg::*;

    localparam int CntW      = $clog2(MaxWords + 1);
    localparam int PackBytes = (PreloadHdrBytes > WordBytes) ? PreloadHdrBytes : WordBytes;

`ifdef DMEM_PRELOAD_CSUM_EN
    localparam preload_state_e StAfterData = ST_TAIL;
`else
    localparam preload_state_e StAfterData = ST_DONE;
`endif

    preload_state_e          r_state;
    preload_state_e          w_state_nxt;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_pack_accept;
    logic                    w_start;
    logic [8*PackBytes-1:0]  w_word;
    logic                    w_word_valid;
    logic                    w_cnt_zero;
    logic                    w_cnt_over;
    logic [CntW-1:0]         w_idx_nxt;
    logic [ADW-1:0]          w_offset;

    logic [ADW-1:0]          r_base;
    logic [ADW-1:0]          r_addr;
    logic [CntW-1:0]         r_count;
    logic [CntW-1:0]         r_idx;
    logic [DPW-1:0]          r_data;
    logic                    r_err;
`ifdef DMEM_PRELOAD_CSUM_EN
    logic [7:0]              r_csum;
`endif

    // Ready depends on state only, so the packer's word_valid can feed the FSM without a loop.
    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            ST_HDR_ADDR, ST_HDR_CNT, ST_DATA: w_ready = 1'b1;
`ifdef DMEM_PRELOAD_CSUM_EN
            ST_TAIL:                          w_ready = 1'b1;
`endif
            default:                          w_ready = 1'b0;
        endcase
    end

    assign s_ready_o     = w_ready;
    assign w_accept      = s_valid_i && w_ready;
    // The checksum byte is not part of any word, keep it out of the packer.
    assign w_pack_accept = w_accept && (r_state inside {ST_HDR_ADDR, ST_HDR_CNT, ST_DATA});
    assign w_start       = (r_state == ST_IDLE) && start_i;

    assign w_cnt_zero = (w_word == '0);
    assign w_cnt_over = (w_word > DPW'(MaxWords));   // full 32-bit compare: high COUNT bits matter
    assign w_idx_nxt  = r_idx + CntW'(1);
    assign w_offset   = ADW'({r_idx, 2'b00});

    preload_byte_packer #(
        .Bytes        (PackBytes)
    ) u_packer (
        .clk          (clk),
        .arst_ni      (arst_ni),
        .i_clear      (w_start),
        .i_accept     (w_pack_accept),
        .i_byte       (s_data_i),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        data_en_o   = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_state_nxt = ST_HDR_ADDR;
            end
            ST_HDR_ADDR: begin
                if (w_word_valid) w_state_nxt = ST_HDR_CNT;
            end
            ST_HDR_CNT: begin
                if (w_word_valid) begin
                    if (w_cnt_zero)      w_state_nxt = StAfterData;
                    else if (w_cnt_over) w_state_nxt = ST_DONE;
                    else                 w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_valid) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                data_en_o   = 1'b1;
                w_state_nxt = (w_idx_nxt < r_count) ? ST_DATA : StAfterData;
            end
`ifdef DMEM_PRELOAD_CSUM_EN
            ST_TAIL: begin
                if (s_valid_i) w_state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                busy_o      = 1'b0;
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                busy_o      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address/data are captured as the last byte of a word arrives, so they are stable
    // during the WRITE cycle and simply hold afterwards.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            r_base  <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
`ifdef DMEM_PRELOAD_CSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            if (w_start) begin
                r_err <= 1'b0;
                r_idx <= '0;
`ifdef DMEM_PRELOAD_CSUM_EN
                r_csum <= '0;
`endif
            end
            if (r_state == ST_HDR_ADDR && w_word_valid) begin
                r_base <= w_word[ADW-1:0];
            end
            if (r_state == ST_HDR_CNT && w_word_valid) begin
                r_count <= w_word[CntW-1:0];
                r_idx   <= '0;
                if (w_cnt_over) r_err <= 1'b1;
            end
            if (r_state == ST_DATA && w_word_valid) begin
                r_addr <= r_base + w_offset;
                r_data <= w_word;
            end
            if (r_state == ST_WRITE) begin
                r_idx <= w_idx_nxt;
            end
`ifdef DMEM_PRELOAD_CSUM_EN
            if (r_state == ST_DATA && w_accept) begin
                r_csum <= r_csum ^ s_data_i;
            end
            if (r_state == ST_TAIL && w_accept && (s_data_i != r_csum)) begin
                r_err <= 1'b1;
            end
`endif
        end
    end

    assign input_addr_o = DPW'(r_addr);
    assign input_data_o = r_data;
    assign err_o        = r_err;

endmodule

// File: tb/tb_dmem_preloader.sv
// tb/tb_dmem_preloader.sv - self-checking bench for dmem_preloader (vector table + random sessions)
module tb_dmem_preloader;

`ifdef DMEM_PRELOAD_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int          MAXW  = 30;
    localparam logic [31:0] AMASK = (32'd1 << rv32i_pkg::ADW) - 32'd1;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic        start_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic        data_en_o;
    logic [31:0] input_addr_o;
    logic [31:0] input_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    dmem_preloader dut (
        .clk          (clk),
        .arst_ni      (arst_ni),
        .start_i      (start_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .data_en_o    (data_en_o),
        .input_addr_o (input_addr_o),
        .input_data_o (input_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every write and done pulse, sampled mid-cycle.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    bit          wr_rdy[$];
    bit          wr_busy[$];
    bit          wr_prev[$];
    bit          prev_en   = 1'b0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    bit          done_err  = 1'b0;
    bit          done_busy = 1'b0;

    always @(negedge clk) begin
        if (data_en_o) begin
            wr_addr.push_back(input_addr_o);
            wr_data.push_back(input_data_o);
            wr_cyc.push_back(cyc);
            wr_rdy.push_back(s_ready_o);
            wr_busy.push_back(busy_o);
            wr_prev.push_back(prev_en);
        end
        if (done_o) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_err  <= err_o;
            done_busy <= busy_o;
        end
        prev_en <= data_en_o;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", nm, got, exp);
        end
    endtask

    int acc_cyc[$];

    // Drives a start pulse then the first 'limit' bytes; gap 0 = always valid,
    // 1 = valid every other cycle, 2 = random valid.
    task automatic drive(input logic [7:0] st[$], input int gap, input int limit);
        int idx    = 0;
        int budget = 0;
        bit acc;
        acc_cyc.delete();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        while (idx < limit && budget < 5000) begin
            case (gap)
                0:       s_valid_i = 1'b1;
                1:       s_valid_i = budget[0];
                default: s_valid_i = 1'($urandom_range(0, 1));
            endcase
            s_data_i = st[idx];
            #3;
            acc = s_valid_i && s_ready_o;
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            budget++;
        end
        s_valid_i = 1'b0;
        if (idx < limit) chk("stream_timeout", idx, limit);
    endtask

    // One full session checked against the stream rules: writes at (BASE+4i) mod 2^ADW,
    // err on COUNT>MaxWords (or bad tail byte when the checksum build is used).
    task automatic session(input logic [31:0] base, input logic [31:0] count,
                           input logic [31:0] words[$], input int gap, input bit bad_tail,
                           output int nwr, output logic [31:0] a0, output logic [31:0] d0,
                           output bit gerr);
        logic [7:0] st[$];
        logic [7:0] x    = 8'h00;
        int   w0         = wr_addr.size();
        int   dc0        = done_cnt;
        bit   ovf        = (count > MAXW);
        int   n_exp      = ovf ? 0 : int'(count);
        bit   exp_err    = ovf;
        int   b          = 0;
        int   last;
        for (int k = 0; k < 4; k++) st.push_back(base[8*k +: 8]);
        for (int k = 0; k < 4; k++) st.push_back(count[8*k +: 8]);
        for (int i = 0; i < n_exp; i++) begin
            for (int k = 0; k < 4; k++) begin
                st.push_back(words[i][8*k +: 8]);
                x ^= words[i][8*k +: 8];
            end
        end
        if (CSUM && !ovf) begin
            st.push_back(bad_tail ? ((x == 8'h00) ? 8'hFF : 8'h00) : x);
            exp_err = bad_tail;
        end
        drive(st, gap, st.size());
        while (done_cnt == dc0 && b < 100) begin
            @(negedge clk); #1;
            b++;
        end
        chk("done_seen", done_cnt - dc0, 1);
        nwr = wr_addr.size() - w0;
        chk("num_writes", nwr, n_exp);
        for (int j = 0; j < nwr && j < n_exp; j++) begin
            chk("wr_addr", wr_addr[w0+j], (base + 32'(4*j)) & AMASK);
            chk("wr_data", wr_data[w0+j], words[j]);
            chk("wr_ready_low", wr_rdy[w0+j], 0);
            chk("wr_busy", wr_busy[w0+j], 1);
            chk("wr_single_pulse", wr_prev[w0+j], 0);
            if (8 + 4*j + 3 < acc_cyc.size())
                chk("wr_latency", wr_cyc[w0+j], acc_cyc[8 + 4*j + 3]);
        end
        if (acc_cyc.size() > 0) begin
            last = acc_cyc[acc_cyc.size()-1];
            chk("done_timing", done_cyc, last + ((n_exp > 0 && !CSUM) ? 1 : 0));
        end
        chk("err_at_done", done_err, exp_err);
        chk("busy_at_done", done_busy, 0);
        @(negedge clk); #1;
        chk("done_one_cycle", done_o, 0);
        chk("err_sticky", err_o, exp_err);
        chk("busy_after", busy_o, 0);
        a0   = (nwr > 0) ? wr_addr[w0] : 32'h0;
        d0   = (nwr > 0) ? wr_data[w0] : 32'h0;
        gerr = done_err;
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] count;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        bit          bad;
        int          exp_nwr;
        bit          exp_ovf;
        logic [31:0] exp_a0;
        logic [31:0] exp_d0;
    } vec_t;

    vec_t vt[9];

    initial begin
        int          nwr;
        logic [31:0] a0;
        logic [31:0] d0;
        bit          gerr;
        logic [31:0] wq[$];
        logic [7:0]  st[$];
        int          w0;

        vt[0] = '{32'h0000_0000, 32'd2,          32'h0000_0005, 32'h0000_000A, 0, 1'b0, 2,  1'b0, 32'h00, 32'h0000_0005};
        vt[1] = '{32'h0000_0000, 32'd2,          32'h0000_0005, 32'h0000_000A, 1, 1'b1, 2,  1'b0, 32'h00, 32'h0000_0005};
        vt[2] = '{32'h0000_0010, 32'd0,          32'h0,         32'h0,         0, 1'b0, 0,  1'b0, 32'h00, 32'h0};
        vt[3] = '{32'h0000_0000, 32'h1F,         32'h0,         32'h0,         0, 1'b0, 0,  1'b1, 32'h00, 32'h0};
        vt[4] = '{32'h0000_007C, 32'd3,          32'hDEAD_BEEF, 32'h1234_5678, 2, 1'b0, 3,  1'b0, 32'h7C, 32'hDEAD_BEEF};
        vt[5] = '{32'h0000_0003, 32'd2,          32'hA5A5_5A5A, 32'h0000_0001, 0, 1'b1, 2,  1'b0, 32'h03, 32'hA5A5_5A5A};
        vt[6] = '{32'h0000_0000, 32'd30,         32'h1122_3344, 32'h5566_7788, 0, 1'b0, 30, 1'b0, 32'h00, 32'h1122_3344};
        vt[7] = '{32'h0000_0000, 32'h0001_0001,  32'h0,         32'h0,         0, 1'b0, 0,  1'b1, 32'h00, 32'h0};
        vt[8] = '{32'hFFFF_FF80, 32'd1,          32'hCAFE_F00D, 32'h0,         1, 1'b0, 1,  1'b0, 32'h00, 32'hCAFE_F00D};

        arst_ni   = 1'b0;
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  s_ready_o,    0);
        chk("rst_en",     data_en_o,    0);
        chk("rst_addr",   input_addr_o, 0);
        chk("rst_data",   input_data_o, 0);
        chk("rst_busy",   busy_o,       0);
        chk("rst_done",   done_o,       0);
        chk("rst_err",    err_o,        0);
        @(posedge clk); #1 arst_ni = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            wq.delete();
            for (int k = 0; k < MAXW; k++)
                wq.push_back((k == 0) ? vt[i].w0 : (k == 1) ? vt[i].w1 : $urandom);
            session(vt[i].base, vt[i].count, wq, vt[i].gap, vt[i].bad, nwr, a0, d0, gerr);
            chk("tbl_nwr", nwr, vt[i].exp_nwr);
            chk("tbl_err", gerr, vt[i].exp_ovf | (CSUM & vt[i].bad));
            if (vt[i].exp_nwr > 0) begin
                chk("tbl_addr0", a0, vt[i].exp_a0);
                chk("tbl_data0", d0, vt[i].exp_d0);
            end
        end

        for (int r = 0; r < 8; r++) begin
            wq.delete();
            for (int k = 0; k < MAXW; k++) wq.push_back($urandom);
            session($urandom, 32'($urandom_range(1, 6)), wq, 2, 1'($urandom_range(0, 1)),
                    nwr, a0, d0, gerr);
        end

        // Reset in the middle of word 1 of a 3-word load.
        st.delete();
        for (int k = 0; k < 4; k++) st.push_back(8'(32'h20 >> (8*k)));
        for (int k = 0; k < 4; k++) st.push_back(8'(32'd3 >> (8*k)));
        for (int k = 0; k < 12; k++) st.push_back(8'($urandom));
        w0 = wr_addr.size();
        drive(st, 0, 14);
        arst_ni = 1'b0;
        #1;
        chk("mid_rst_ready", s_ready_o,    0);
        chk("mid_rst_en",    data_en_o,    0);
        chk("mid_rst_addr",  input_addr_o, 0);
        chk("mid_rst_data",  input_data_o, 0);
        chk("mid_rst_busy",  busy_o,       0);
        chk("mid_rst_done",  done_o,       0);
        chk("mid_rst_err",   err_o,        0);
        repeat (4) @(posedge clk);
        #1 arst_ni = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_writes", wr_addr.size() - w0, 1);
        wq.delete();
        for (int k = 0; k < MAXW; k++) wq.push_back($urandom);
        session(32'h40, 32'd3, wq, 0, 1'b0, nwr, a0, d0, gerr);
        chk("post_rst_addr0", a0, 32'h40);
        chk("post_rst_data0", d0, wq[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_preloader.md
Name: dmem_preloader

Overview:
- Producer end of the d_cache preload port (data_en / input_addr / input_data).
- Receives a byte stream over a valid/ready handshake, for example from a UART receiver or debug bridge.
- Assembles little-endian 32-bit words and writes them into the data memory before the core is released from reset.
- busy_o holds the core in reset while loading is in progress.

Parameters:
- DPW, rv32i_pkg::DPW (32): data word width; must be 32.
- ADW, rv32i_pkg::ADW: address width driven on input_addr_o.
- MaxWords, 30: largest word count accepted (120-byte d_cache / 4).

Ports:
- clk  in  1  system clock, rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that starts a load session.
- s_data_i  in  8  stream byte.
- s_valid_i  in  1  stream byte valid.
- s_ready_o  out  1  block accepts the byte this cycle.
- data_en_o  out  1  d_cache preload write strobe.
- input_addr_o  out  DPW  preload byte address, zero-extended from ADW.
- input_data_o  out  DPW  preload word.
- busy_o  out  1  session in progress; gates core reset.
- done_o  out  1  one-cycle pulse at the end of a session.
- err_o  out  1  sticky error flag for the last session.

Behaviour:
- Reset (async, arst_ni=0): state IDLE. All outputs are 0: s_ready_o, data_en_o, input_addr_o, input_data_o, busy_o, done_o, err_o. Byte counter and word counter are cleared.
- Reset mid-session aborts immediately. No further data_en_o is issued.
- A byte transfers on a rising clk edge when s_valid_i && s_ready_o. s_data_i is sampled on that edge.
- Stream format, all fields little-endian:
  - 4 bytes BASE address.
  - 4 bytes COUNT (number of words N).
  - N×4 data bytes.
- State machine:
  - IDLE: s_ready_o=0. On start_i, go to HDR_ADDR, set busy_o=1, clear err_o.
  - HDR_ADDR: s_ready_o=1. After byte 3 is accepted, BASE is latched; go to HDR_CNT.
  - HDR_CNT: s_ready_o=1. After byte 3 is accepted:
    - COUNT=0: go to DONE.
    - COUNT>MaxWords: set err_o=1 and go to DONE.
    - Otherwise go to DATA.
  - DATA: s_ready_o=1. Shifts bytes into the word register, byte 0 into bits [7:0]. After byte 3 is accepted, go to WRITE.
  - WRITE: one cycle only. s_ready_o=0, data_en_o=1.
    - input_addr_o = BASE + 4*i, where i is the word index starting at 0. The sum wraps modulo 2^ADW.
    - input_data_o = the assembled word.
    - Next state is DATA if i+1<COUNT, else TAIL (if the feature is enabled) or DONE.
  - DONE: done_o=1 for one cycle, busy_o=0 in this same cycle, then go to IDLE.
- Latency and throughput:
  - data_en_o rises the cycle after the 4th byte of a word is accepted.
  - Best case is 5 cycles per word.
  - BASE is the 4th header byte accepted plus 1 cycle.
- input_addr_o and input_data_o hold their last values after WRITE. data_en_o is strictly a single-cycle pulse.
- start_i is ignored while busy_o=1.
- s_valid_i gaps simply stall the current state; no timeout.
- BASE is used as given. Unaligned BASE is not corrected, and words are written at BASE+4i.

Optional Feature:
- Macro: DMEM_PRELOAD_CSUM_EN.
- Defined:
  - After the last WRITE, state TAIL accepts one extra byte, with s_ready_o=1.
  - The expected byte is the XOR of all N×4 data bytes.
  - On mismatch, err_o=1. Then go to DONE.
  - When COUNT=0, TAIL is still entered and expects 0x00.
- Undefined: no TAIL state and no checksum logic. err_o is set only by a COUNT overflow.

Decomposition:
- rv32i_pkg gains:
  - the state enum typedef preload_state_e;
  - localparam PreloadHdrBytes = 4;
  - localparam WordBytes = DPW/8.
- One sub-module, preload_byte_packer: the shift register, byte counter (0..3) and word_valid pulse. It is reused for BASE, COUNT and data words.

Test Plan:
- Basic load: start; stream 00 00 00 00 | 02 00 00 00 | 05 00 00 00 | 0A 00 00 00.
  - Expect two data_en_o pulses: (addr 0x0, data 0x00000005) then (addr 0x4, data 0x0000000A).
  - Then a done_o pulse, err_o=0.
  - A d_cache read at 0x0 then returns 0x05.
- Backpressure and gaps: same stream with s_valid_i toggling every other cycle.
  - Identical writes.
  - s_ready_o=0 exactly in the WRITE cycles.
- Zero count: header 10 00 00 00 | 00 00 00 00.
  - No data_en_o, done_o 1 cycle later, busy_o drops.
- Overflow: COUNT=0x1F (31 > 30).
  - err_o=1, done_o pulse, no data_en_o.
- Reset mid-session: assert arst_ni low during word 1 of a 3-word load.
  - All outputs 0 at once.
  - A new start plus a full stream then works normally.
- With DMEM_PRELOAD_CSUM_EN: basic load plus tail 0x0F gives err_o=0; tail 0x00 gives err_o=1.
